// File: rtl/shift_stage.sv
// Two-stage MIPS R-type shift pipeline: S1 decodes and drives an external
// combinational barrel shifter, S2 captures its result for a valid/ready output.
module shift_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] sh_a,
  output logic [4:0]  sh_b,
  output logic [1:0]  sh_aluc,
  input  logic [31:0] sh_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_zero,
  output logic        out_illegal,
  output logic [15:0] op_count
);

  logic        s1_valid_r;
  logic [31:0] s1_a_r;
  logic [4:0]  s1_b_r;
  logic [1:0]  s1_aluc_r;
  logic        s1_illegal_r;

  logic        s2_valid_r;
  logic [31:0] s2_data_r;
  logic        s2_zero_r;
  logic        s2_illegal_r;

  logic [15:0] op_count_r;

  logic        adv_s;
  logic        in_xfer_s;
  logic        out_xfer_s;
  logic [31:0] dec_a_s;
  logic [4:0]  dec_b_s;
  logic [1:0]  dec_aluc_s;
  logic        dec_illegal_s;
  logic [31:0] s2_next_data_s;

  assign adv_s      = s1_valid_r && (!s2_valid_r || out_ready);
  assign in_ready   = !s1_valid_r || adv_s;
  assign in_xfer_s  = in_valid && in_ready;
  assign out_xfer_s = s2_valid_r && out_ready;

  // Decode funct into shifter operands; unknown functs become zero-operand left shifts
  always_comb begin
    dec_a_s       = rt_val;
    dec_b_s       = 5'd0;
    dec_aluc_s    = 2'b01;
    dec_illegal_s = 1'b0;
    case (funct)
      6'b000000: begin dec_b_s = shamt;       dec_aluc_s = 2'b01; end
      6'b000010: begin dec_b_s = shamt;       dec_aluc_s = 2'b10; end
      6'b000011: begin dec_b_s = shamt;       dec_aluc_s = 2'b00; end
      6'b000100: begin dec_b_s = rs_val[4:0]; dec_aluc_s = 2'b01; end
      6'b000110: begin dec_b_s = rs_val[4:0]; dec_aluc_s = 2'b10; end
      6'b000111: begin dec_b_s = rs_val[4:0]; dec_aluc_s = 2'b00; end
      default: begin
        dec_a_s       = 32'd0;
        dec_b_s       = 5'd0;
        dec_aluc_s    = 2'b01;
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // Illegal instructions still flow but their result is forced to zero
  always_comb begin
    if (s1_illegal_r) begin
      s2_next_data_s = 32'd0;
    end else begin
      s2_next_data_s = sh_c;
    end
  end

  // S1 register: capture decoded instruction, drain on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_a_r       <= 32'd0;
      s1_b_r       <= 5'd0;
      s1_aluc_r    <= 2'b00;
      s1_illegal_r <= 1'b0;
    end else if (in_xfer_s) begin
      s1_valid_r   <= 1'b1;
      s1_a_r       <= dec_a_s;
      s1_b_r       <= dec_b_s;
      s1_aluc_r    <= dec_aluc_s;
      s1_illegal_r <= dec_illegal_s;
    end else if (adv_s) begin
      s1_valid_r   <= 1'b0;
    end
  end

  // S2 register: capture shifter result on advance, clear after output transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r   <= 1'b0;
      s2_data_r    <= 32'd0;
      s2_zero_r    <= 1'b0;
      s2_illegal_r <= 1'b0;
    end else if (adv_s) begin
      s2_valid_r   <= 1'b1;
      s2_data_r    <= s2_next_data_s;
      s2_zero_r    <= (s2_next_data_s == 32'd0);
      s2_illegal_r <= s1_illegal_r;
    end else if (out_xfer_s) begin
      s2_valid_r   <= 1'b0;
    end
  end

  // Saturating count of output transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= 16'd0;
    end else if (out_xfer_s && (op_count_r != 16'hFFFF)) begin
      op_count_r <= op_count_r + 16'd1;
    end
  end

  assign sh_a        = s1_a_r;
  assign sh_b        = s1_b_r;
  assign sh_aluc     = s1_aluc_r;
  assign out_valid   = s2_valid_r;
  assign out_data    = s2_data_r;
  assign out_zero    = s2_zero_r;
  assign out_illegal = s2_illegal_r;
  assign op_count    = op_count_r;

endmodule

// File: doc/shift_stage.md
SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have rst_n, input, 1; reset is asynchronous, active-low.
REQ-003 SHALL have in_valid, input, 1, upstream presents an instruction.
REQ-004 SHALL have in_ready, output, 1, stage accepts the instruction this cycle.
REQ-005 SHALL have funct, input, 6, MIPS R-type function field.
REQ-006 SHALL have shamt, input, 5, immediate shift amount.
REQ-007 SHALL have rs_val, input, 32, rs operand; bits [4:0] are the variable shift amount.
REQ-008 SHALL have rt_val, input, 32, value to be shifted.
REQ-009 SHALL have sh_a, output, 32; sh_b, output, 5; sh_aluc, output, 2; these drive the combinational barrel shifter.
REQ-010 SHALL have sh_c, input, 32, combinational result returned by the barrel shifter.
REQ-011 SHALL have out_valid, output, 1, and out_ready, input, 1, downstream handshake.
REQ-012 SHALL have out_data, output, 32; out_zero, output, 1; out_illegal, output, 1.
REQ-013 SHALL have op_count, output, 16, count of completed transfers on the output port.

Function
REQ-014 Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
REQ-015 Stage 1 (S1) register: holds a, b, aluc, illegal, valid. sh_a/sh_b/sh_aluc driven directly from S1 registers.
REQ-016 Decode at capture:
- 000000 sll: b=shamt, aluc=01
- 000010 srl: b=shamt, aluc=10
- 000011 sra: b=shamt, aluc=00
- 000100 sllv: b=rs_val[4:0], aluc=01
- 000110 srlv: b=rs_val[4:0], aluc=10
- 000111 srav: b=rs_val[4:0], aluc=00
- a=rt_val in all cases.
REQ-017 Any other funct: illegal=1, a=0, b=0, aluc=01; the instruction still flows through the pipeline.
REQ-018 Stage 2 (S2) register: captures sh_c (forced to 0 if S1 illegal), out_zero=(captured value==0), and out_illegal; out_data/out_zero/out_illegal/out_valid come directly from S2.
REQ-019 S1 advance condition: adv = S1.valid && (!S2.valid || out_ready).
REQ-020 in_ready = !S1.valid || adv (combinational; full throughput, 1 transfer/cycle sustained).
REQ-021 Latency: an instruction accepted at edge N SHALL appear with out_valid=1 after edge N+1.
REQ-022 Backpressure: while out_valid && !out_ready, S2 holds every output stable. S1 holds if occupied. in_ready drops to 0 once both stages are full.
REQ-023 Simultaneous events: input transfer, S1->S2 advance and output transfer in the same cycle SHALL all complete with no bubble and no loss.
REQ-024 S2 valid clears on an output transfer with no S1 advance. S1 valid clears on an advance with no input transfer.
REQ-025 op_count increments by 1 per output transfer (illegal included) and saturates at 0xFFFF with no wrap.
REQ-026 Ordering: outputs SHALL appear in strict acceptance order; no instruction is dropped or duplicated.

Reset
REQ-027 rst_n low SHALL immediately clear S1.valid, S2.valid and op_count, and zero all S1/S2 data registers.
REQ-028 During reset: out_valid=0, out_data=0, out_zero=0, out_illegal=0, sh_a=0, sh_b=0, sh_aluc=00, in_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight instructions. The first transfer after deassertion behaves as from idle.

Verification
REQ-030 sra, rt_val=0x80000000, shamt=4, out_ready=1 -> 2 edges later out_data=0xF8000000, out_zero=0. srl with the same operands -> 0x08000000.
REQ-031 sllv, rs_val=0x00000025, rt_val=0x00000003 -> sh_b=5, out_data=0x00000060. srav, rs_val=0x1F, rt_val=0x7FFFFFFF -> out_data=0, out_zero=1.
REQ-032 Back-to-back sll of 0x1 by 1, 2, 3 on consecutive cycles with out_ready=1 -> out_data 0x2, 0x4, 0x8 on consecutive cycles; in_ready stays 1.
REQ-033 out_ready=0 with 3 instructions offered -> two accepted, in_ready=0 on the third, out_data stable. Release out_ready -> all three emitted in order, op_count=3.
REQ-034 funct=100000 -> out_illegal=1, out_data=0, out_zero=1, op_count increments.
REQ-035 rst_n pulsed low with both stages full -> out_valid=0 asynchronously, op_count=0, no stale result emitted after release.
